// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and frame builder for the Clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] ST_BITS = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] TA_WR   = 2'b10;

  localparam int FRAME_BITS = 64;
  localparam int PRE_BITS   = 32;
  localparam int IDX_TA     = 46;
  localparam int IDX_DATA   = 48;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Frame image with bit 0 (first on the wire) at the MSB; for reads the
  // turnaround and data fields are filled with ones since the line is released.
  function automatic logic [FRAME_BITS-1:0] buildFrame(input logic       isRead,
                                                       input logic [4:0] phyAd,
                                                       input logic [4:0] regAd,
                                                       input logic [15:0] data);
    buildFrame = {{PRE_BITS{1'b1}}, ST_BITS, (isRead ? OP_RD : OP_WR), phyAd, regAd,
                  (isRead ? 2'b11 : TA_WR), (isRead ? 16'hFFFF : data)};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: DIV_HALF clocks low then DIV_HALF clocks high, parked low when disabled.
module mdio_clk_gen #(
  parameter int DIV_HALF = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mdc_q, mdc_d;
  logic             wrap;

  assign wrap     = en && (cnt_q == CNT_LAST);
  assign rise_stb = wrap && !mdc_q;
  assign fall_stb = wrap && mdc_q;
  assign mdc      = mdc_q;

  // Half-period counter; a wrap toggles mdc, and disabling restarts a low phase.
  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      mdc_d = !mdc_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and mdc registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one 64-bit read/write frame per request.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int DIV_HALF = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  phy_add,
  input  logic [4:0]  reg_add,
  input  logic [15:0] wr_data,
  input  logic        wren,
  input  logic        rden,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [5:0] BIT_OE_OFF = 6'(IDX_TA - 1);
  localparam logic [5:0] BIT_TA_SMP = 6'(IDX_TA + 1);
  localparam logic [5:0] BIT_DATA   = 6'(IDX_DATA);
  localparam logic [5:0] BIT_LAST   = 6'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shiftReg_q, shiftReg_d;
  logic [5:0]              bitCnt_q, bitCnt_d;
  logic                    isRead_q, isRead_d;
  logic                    mdioOe_q, mdioOe_d;
  logic [15:0]             capture_q, capture_d;
  logic                    taErr_q, taErr_d;
  logic [15:0]             rdData_q, rdData_d;
  logic                    rdValid_q, rdValid_d;
  logic                    rdErr_q, rdErr_d;

  logic [FRAME_BITS-1:0]   loadFrame;
  logic                    genEn, genMdc, riseStb, fallStb;

  // The generator keeps running through DONE to time the tail gap, but the
  // pin only sees mdc while bits are actually being shifted.
  assign genEn     = (state_q != IDLE);
  assign loadFrame = buildFrame(!wren, phy_add, reg_add, wr_data);

  mdio_clk_gen #(.DIV_HALF(DIV_HALF)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (genEn),
    .mdc      (genMdc),
    .rise_stb (riseStb),
    .fall_stb (fallStb)
  );

  assign busy     = (state_q != IDLE);
  assign mdc      = genMdc && (state_q == SHIFT);
  assign mdio_o   = shiftReg_q[FRAME_BITS-1];
  assign mdio_oe  = mdioOe_q;
  assign rd_data  = rdData_q;
  assign rd_valid = rdValid_q;
  assign rd_err   = rdErr_q;

  // Next-state logic: load the frame on accept, shift on mdc falls, sample on mdc rises.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    isRead_d   = isRead_q;
    mdioOe_d   = mdioOe_q;
    capture_d  = capture_q;
    taErr_d    = taErr_q;
    rdData_d   = rdData_q;
    rdValid_d  = 1'b0;
    rdErr_d    = rdErr_q;

    case (state_q)
      IDLE: begin
        if (wren || rden) begin
          state_d    = SHIFT;
          isRead_d   = !wren;
          shiftReg_d = loadFrame;
          bitCnt_d   = '0;
          mdioOe_d   = 1'b1;
          capture_d  = '0;
          taErr_d    = 1'b0;
        end
      end

      SHIFT: begin
        if (riseStb) begin
          if (isRead_q && (bitCnt_q == BIT_TA_SMP)) begin
            taErr_d = mdio_i;
          end
          if (bitCnt_q >= BIT_DATA) begin
            capture_d = {capture_q[14:0], mdio_i};
          end
        end
        if (fallStb) begin
          if (bitCnt_q == BIT_LAST) begin
            state_d    = DONE;
            shiftReg_d = '1;
            mdioOe_d   = 1'b0;
          end else begin
            bitCnt_d   = bitCnt_q + 1'b1;
            shiftReg_d = {shiftReg_q[FRAME_BITS-2:0], 1'b1};
            if (isRead_q && (bitCnt_q == BIT_OE_OFF)) begin
              mdioOe_d = 1'b0;
            end
          end
        end
      end

      DONE: begin
        if (fallStb) begin
          state_d = IDLE;
          if (isRead_q) begin
            rdData_d  = capture_q;
            rdErr_d   = taErr_q;
            rdValid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '1;
      bitCnt_q   <= '0;
      isRead_q   <= 1'b0;
      mdioOe_q   <= 1'b0;
      capture_q  <= '0;
      taErr_q    <= 1'b0;
      rdData_q   <= '0;
      rdValid_q  <= 1'b0;
      rdErr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
      isRead_q   <= isRead_d;
      mdioOe_q   <= mdioOe_d;
      capture_q  <= capture_d;
      taErr_q    <= taErr_d;
      rdData_q   <= rdData_d;
      rdValid_q  <= rdValid_d;
      rdErr_q    <= rdErr_d;
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master with a simple PHY model and frame rules.
module tb_mdio_master;

  localparam int DIV = 2;
  localparam logic [63:0] READ_DRIVEN = 64'h0000_3FFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  phy_add;
  logic [4:0]  reg_add;
  logic [15:0] wr_data;
  logic        wren;
  logic        rden;
  logic        busy;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] lastRdData = 16'h0;
  logic        lastRdErr  = 1'b0;

  mdio_master #(.DIV_HALF(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .phy_add  (phy_add),
    .reg_add  (reg_add),
    .wr_data  (wr_data),
    .wren     (wren),
    .rden     (rden),
    .busy     (busy),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_err   (rd_err),
    .mdc      (mdc),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .mdio_i   (mdio_i)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Expected wire sequence, indexed by bit position on the wire.
  function automatic logic [63:0] expectedFrame(input logic isRead, input logic [4:0] phy,
                                                input logic [4:0] regA, input logic [15:0] data);
    logic [63:0] f;
    for (int i = 0; i < 64; i++) begin
      if (i < 32)       f[i] = 1'b1;
      else if (i == 32) f[i] = 1'b0;
      else if (i == 33) f[i] = 1'b1;
      else if (i == 34) f[i] = isRead;
      else if (i == 35) f[i] = !isRead;
      else if (i < 41)  f[i] = phy[40-i];
      else if (i < 46)  f[i] = regA[45-i];
      else if (i == 46) f[i] = 1'b1;
      else if (i == 47) f[i] = 1'b0;
      else              f[i] = data[63-i];
    end
    return f;
  endfunction

  // PHY model: line pulled high until it drives TA bit 47 and the data field.
  function automatic logic phyBit(input int idx, input logic ta, input logic [15:0] data);
    if (idx < 47 || idx > 63) return 1'b1;
    if (idx == 47) return ta;
    return data[63-idx];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic doWr, input logic doRd, input logic [4:0] phy,
                               input logic [4:0] regA, input logic [15:0] wdata);
    wren    = doWr;
    rden    = doRd;
    phy_add = phy;
    reg_add = regA;
    wr_data = wdata;
  endtask

  // Runs one frame from the accept edge to the first idle cycle and checks it.
  task automatic runFrame(input string name, input logic doWr, input logic doRd,
                          input logic [4:0] phy, input logic [4:0] regA, input logic [15:0] wdata,
                          input logic phyTa, input logic [15:0] phyData,
                          input logic holdReq, input logic preAccepted,
                          input int resetAt, input int pulseAt);
    logic [63:0] gotBits, gotOe, expBits;
    logic        expRead, prevMdc, done, aborted, pulsed, pulseOn;
    int          bitIdx, busyCycles, strayValid, cyc;

    expRead    = !doWr;
    expBits    = expectedFrame(expRead, phy, regA, wdata);
    gotBits    = '0;
    gotOe      = '0;
    prevMdc    = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    pulsed     = 1'b0;
    pulseOn    = 1'b0;
    bitIdx     = 0;
    busyCycles = 0;
    strayValid = 0;
    cyc        = 0;

    if (!preAccepted) applyStimulus(doWr, doRd, phy, regA, wdata);
    mdio_i = phyBit(0, phyTa, phyData);
    @(negedge clk);
    checkOutput({name, "_start"}, {60'd0, busy, mdc, mdio_oe, mdio_o}, 64'hB);
    if (!holdReq) begin
      wren    = 1'b0;
      rden    = 1'b0;
      phy_add = 5'($urandom);
      reg_add = 5'($urandom);
      wr_data = 16'($urandom);
    end

    while (!done && cyc < 1000) begin
      if (!busy) begin
        done = 1'b1;
      end else begin
        busyCycles++;
        if (rd_valid) strayValid++;
        if (mdc && !prevMdc) begin
          gotBits[bitIdx] = mdio_o;
          gotOe[bitIdx]   = mdio_oe;
        end
        if (!mdc && prevMdc) begin
          bitIdx++;
          mdio_i = phyBit(bitIdx, phyTa, phyData);
        end
        prevMdc = mdc;
        if (pulseOn) begin
          wren    = 1'b0;
          pulseOn = 1'b0;
        end else if (!pulsed && pulseAt >= 0 && bitIdx == pulseAt) begin
          wren    = 1'b1;
          pulsed  = 1'b1;
          pulseOn = 1'b1;
        end
        if (resetAt >= 0 && bitIdx == resetAt) begin
          rst = 1'b1;
          #1;
          lastRdData = 16'h0;
          lastRdErr  = 1'b0;
          checkOutput({name, "_abort"}, {59'd0, busy, mdc, mdio_oe, rd_valid, !mdio_o}, 64'd0);
          checkOutput({name, "_abortRd"}, {47'd0, rd_err, rd_data}, {47'd0, lastRdErr, lastRdData});
          @(negedge clk);
          rst     = 1'b0;
          aborted = 1'b1;
          done    = 1'b1;
        end else begin
          @(negedge clk);
          cyc++;
        end
      end
    end

    mdio_i = 1'b1;
    checkOutput({name, "_done"}, {63'd0, done}, 64'd1);
    if (aborted) return;

    checkOutput({name, "_busyLen"}, 64'(busyCycles), 64'(130 * DIV));
    checkOutput({name, "_strayValid"}, 64'(strayValid), 64'd0);
    if (expRead) begin
      lastRdData = phyData;
      lastRdErr  = phyTa;
      checkOutput({name, "_bits"}, gotBits & READ_DRIVEN, expBits & READ_DRIVEN);
      checkOutput({name, "_oe"}, gotOe, READ_DRIVEN);
      checkOutput({name, "_rdValid"}, {63'd0, rd_valid}, 64'd1);
    end else begin
      checkOutput({name, "_bits"}, gotBits, expBits);
      checkOutput({name, "_oe"}, gotOe, '1);
      checkOutput({name, "_rdValid"}, {63'd0, rd_valid}, 64'd0);
    end
    checkOutput({name, "_rdResult"}, {47'd0, rd_err, rd_data}, {47'd0, lastRdErr, lastRdData});

    if (!holdReq) begin
      @(negedge clk);
      checkOutput({name, "_after"}, {62'd0, busy, rd_valid}, 64'd0);
    end
  endtask

  // Directed sequence followed by randomized frames.
  initial begin
    logic [4:0]  rPhy, rReg;
    logic [15:0] rData, rPhyData;
    logic        rIsRd, rTa;
    int          idleMdc;

    rst    = 1'b1;
    mdio_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 16'h0);
    repeat (3) @(negedge clk);
    checkOutput("reset", {42'd0, busy, mdc, mdio_o, mdio_oe, rd_valid, rd_err, rd_data},
                {42'd0, 6'b001000, 16'h0});
    rst = 1'b0;

    idleMdc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mdc || busy || mdio_oe) idleMdc++;
    end
    checkOutput("idleQuiet", 64'(idleMdc), 64'd0);

    $display("[TB] write frame 3100");
    runFrame("wr1", 1'b1, 1'b0, 5'h00, 5'h00, 16'h3100, 1'b1, 16'hFFFF, 1'b0, 1'b0, -1, -1);

    $display("[TB] read frame with PHY answering 0141");
    runFrame("rd1", 1'b0, 1'b1, 5'h01, 5'h02, 16'h0, 1'b0, 16'h0141, 1'b0, 1'b0, -1, -1);

    $display("[TB] read frame with no PHY");
    runFrame("rdNoPhy", 1'b0, 1'b1, 5'h1F, 5'h11, 16'h0, 1'b1, 16'hFFFF, 1'b0, 1'b0, -1, -1);

    $display("[TB] mid-frame request pulse, then simultaneous wren+rden");
    runFrame("wrPulse", 1'b1, 1'b0, 5'h0A, 5'h15, 16'hA5C3, 1'b1, 16'hFFFF, 1'b0, 1'b0, -1, 20);
    runFrame("wrBoth", 1'b1, 1'b1, 5'h13, 5'h06, 16'h5A0F, 1'b1, 16'hFFFF, 1'b0, 1'b0, -1, -1);

    $display("[TB] reset during read, then clean write");
    runFrame("rdAbort", 1'b0, 1'b1, 5'h04, 5'h09, 16'h0, 1'b0, 16'h1234, 1'b0, 1'b0, 40, -1);
    runFrame("wrClean", 1'b1, 1'b0, 5'h1B, 5'h1C, 16'hBEEF, 1'b1, 16'hFFFF, 1'b0, 1'b0, -1, -1);

    $display("[TB] back-to-back writes");
    runFrame("b2b1", 1'b1, 1'b0, 5'h07, 5'h18, 16'hC001, 1'b1, 16'hFFFF, 1'b1, 1'b0, -1, -1);
    runFrame("b2b2", 1'b1, 1'b0, 5'h07, 5'h18, 16'hC001, 1'b1, 16'hFFFF, 1'b0, 1'b1, -1, -1);

    $display("[TB] randomized frames");
    for (int n = 0; n < 6; n++) begin
      rIsRd    = 1'($urandom_range(0, 1));
      rPhy     = 5'($urandom);
      rReg     = 5'($urandom);
      rData    = 16'($urandom);
      rPhyData = 16'($urandom);
      rTa      = 1'($urandom_range(0, 1));
      runFrame($sformatf("rnd%0d", n), !rIsRd, rIsRd, rPhy, rReg, rData, rTa, rPhyData,
               1'b0, 1'b0, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
